// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Lets the instruction-fetch port and the load/store (data) port of the core
//   share one single-port synchronous SRAM. Only one transaction is in flight
//   at a time. Each transaction goes IDLE/RESP -> ISSUE -> WAIT -> RESP.
//   The data port has priority, but a starvation counter forces a fetch grant
//   after STARVE_MAX consecutive arbitrations that the fetch port lost.
//
// Parameters
//   ADDR_W      byte-address width of both requester ports and mem_addr
//   DATA_W      data width; byte strobes are DATA_W/8 wide
//   MEM_LAT     cycles from mem_en to valid mem_rdata (>= 1)
//   STARVE_MAX  fetch losses tolerated before fetch is forced to win (>= 1)
//
// Ports
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   if_req_valid/ready/addr      fetch read request handshake
//   if_rsp_valid/rdata           one-cycle fetch response pulse + held read data
//   d_req_valid/ready/we/addr/wdata/wstrb
//                                data read/write request handshake
//   d_rsp_valid/rdata            one-cycle data response pulse (rdata 0 on writes)
//   mem_en/we/addr/wdata/wstrb   SRAM access strobe and fields (0 outside ISSUE)
//   mem_rdata                    SRAM read data, valid MEM_LAT cycles after mem_en
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_W-1:0]     if_rsp_rdata,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [ADDR_W-1:0]     d_req_addr,
  input  logic [DATA_W-1:0]     d_req_wdata,
  input  logic [DATA_W/8-1:0]   d_req_wstrb,
  output logic                  d_rsp_valid,
  output logic [DATA_W-1:0]     d_rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SCNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WCNT_W-1:0]   wait_cnt;
  logic [SCNT_W-1:0]   starve_cnt;

  logic                lat_owner_d;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [STRB_W-1:0]   lat_wstrb;

  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  logic                arb_en;
  logic                fetch_forced;
  logic                grant_d;
  logic                grant_if;
  logic                wait_last;

  // Arbitration is open in IDLE and in RESP so a new request can be accepted
  // in the same cycle the previous response is presented. Data wins unless
  // the fetch port has been starved STARVE_MAX times in a row.
  always_comb begin
    arb_en       = !rst && ((state == IDLE) || (state == RESP));
    fetch_forced = (starve_cnt == SCNT_W'(STARVE_MAX));
    grant_d      = arb_en && d_req_valid && !(if_req_valid && fetch_forced);
    grant_if     = arb_en && if_req_valid && !grant_d;
    wait_last    = (wait_cnt == WCNT_W'(MEM_LAT - 1));
  end

  // Next-state logic for the single-transaction pipeline.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_d || grant_if) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_last) state_next = RESP;
      RESP:    state_next = (grant_d || grant_if) ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the registered state and the latched request.
  // The SRAM bus is forced to zero outside ISSUE so the memory never sees
  // stale fields.
  always_comb begin
    if_req_ready = grant_if;
    d_req_ready  = grant_d;
    mem_en       = (state == ISSUE);
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = '0;
    if (mem_en) begin
      mem_we    = lat_we;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      mem_wstrb = lat_wstrb;
    end
    if_rsp_valid = (state == RESP) && !lat_owner_d;
    d_rsp_valid  = (state == RESP) && lat_owner_d;
    if_rsp_rdata = if_rdata_q;
    d_rsp_rdata  = d_rdata_q;
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Counts the MEM_LAT cycles spent in WAIT.
  always_ff @(posedge clk) begin
    if (rst)                 wait_cnt <= '0;
    else if (state != WAIT)  wait_cnt <= '0;
    else if (wait_last)      wait_cnt <= '0;
    else                     wait_cnt <= wait_cnt + 1'b1;
  end

  // Starvation counter: bumps on every arbitration the fetch port loses,
  // clears as soon as fetch is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_d && if_req_valid && !fetch_forced) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Request latch. Read requests store zero write data and strobes so the
  // ISSUE cycle can simply replay the latch onto the SRAM bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_owner_d <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_wstrb   <= '0;
    end else if (grant_d) begin
      lat_owner_d <= 1'b1;
      lat_we      <= d_req_we;
      lat_addr    <= d_req_addr;
      lat_wdata   <= d_req_we ? d_req_wdata : '0;
      lat_wstrb   <= d_req_we ? d_req_wstrb : '0;
    end else if (grant_if) begin
      lat_owner_d <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= if_req_addr;
      lat_wdata   <= '0;
      lat_wstrb   <= '0;
    end
  end

  // Response data capture on the last WAIT cycle. Each port keeps its own
  // register so its rdata holds between pulses; write acks return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if ((state == WAIT) && wait_last) begin
      if (lat_owner_d) d_rdata_q  <= lat_we ? '0 : mem_rdata;
      else             if_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Drives two arbiters (MEM_LAT=1 and MEM_LAT=3) each backed by a small
//   behavioural SRAM. Expected responses go into a scoreboard queue; expected
//   point-in-time signal values go into a check queue keyed by cycle. A single
//   monitor on the falling edge does every comparison.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int TMO   = 60;

  localparam int P_A_IF_READY = 0;
  localparam int P_A_D_READY  = 1;
  localparam int P_A_MEM_EN   = 2;
  localparam int P_A_MEM_ADDR = 3;
  localparam int P_A_MEM_WE   = 4;
  localparam int P_A_OUT_OR   = 5;
  localparam int P_B_OUT_OR   = 6;
  localparam int P_A_IF_RDATA = 7;
  localparam int P_B_RSP_ANY  = 8;
  localparam int P_B_MEM_EN   = 9;
  localparam int P_SB_LEFT    = 10;
  localparam int P_TIMEOUTS   = 11;

  typedef struct {
    int          inst;
    logic        is_d;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  exp_t sb[$];
  chk_t cq[$];

  int vectors;
  int miscompares;
  int timeouts;
  int cyc;

  logic clk = 1'b0;
  logic rst;

  // Instance A signals (MEM_LAT = 1)
  logic        a_if_req_valid, a_if_req_ready, a_if_rsp_valid;
  logic [31:0] a_if_req_addr, a_if_rsp_rdata;
  logic        a_d_req_valid, a_d_req_ready, a_d_req_we, a_d_rsp_valid;
  logic [31:0] a_d_req_addr, a_d_req_wdata, a_d_rsp_rdata;
  logic [3:0]  a_d_req_wstrb;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_wstrb;

  // Instance B signals (MEM_LAT = 3)
  logic        b_if_req_valid, b_if_req_ready, b_if_rsp_valid;
  logic [31:0] b_if_req_addr, b_if_rsp_rdata;
  logic        b_d_req_valid, b_d_req_ready, b_d_req_we, b_d_rsp_valid;
  logic [31:0] b_d_req_addr, b_d_req_wdata, b_d_rsp_rdata;
  logic [3:0]  b_d_req_wstrb;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_wstrb;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_A), .STARVE_MAX(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .if_req_valid(a_if_req_valid), .if_req_ready(a_if_req_ready), .if_req_addr(a_if_req_addr),
    .if_rsp_valid(a_if_rsp_valid), .if_rsp_rdata(a_if_rsp_rdata),
    .d_req_valid(a_d_req_valid), .d_req_ready(a_d_req_ready), .d_req_we(a_d_req_we),
    .d_req_addr(a_d_req_addr), .d_req_wdata(a_d_req_wdata), .d_req_wstrb(a_d_req_wstrb),
    .d_rsp_valid(a_d_rsp_valid), .d_rsp_rdata(a_d_rsp_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb), .mem_rdata(a_mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_B), .STARVE_MAX(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .if_req_valid(b_if_req_valid), .if_req_ready(b_if_req_ready), .if_req_addr(b_if_req_addr),
    .if_rsp_valid(b_if_rsp_valid), .if_rsp_rdata(b_if_rsp_rdata),
    .d_req_valid(b_d_req_valid), .d_req_ready(b_d_req_ready), .d_req_we(b_d_req_we),
    .d_req_addr(b_d_req_addr), .d_req_wdata(b_d_req_wdata), .d_req_wstrb(b_d_req_wstrb),
    .d_rsp_valid(b_d_rsp_valid), .d_rsp_rdata(b_d_rsp_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model A: one-cycle latency; read data is only valid in the single
  // cycle after mem_en, otherwise it shows a poison value.
  logic [31:0] a_mem [256];
  logic [31:0] a_rpipe;
  bit          a_init_done;
  always @(posedge clk) begin
    if (!a_init_done) begin
      for (int i = 0; i < 256; i++)
        a_mem[i] <= (i == 4) ? 32'hDEAD_BEEF : (32'h5A00_0000 | 32'(i));
      a_init_done <= 1'b1;
    end else if (a_mem_en && a_mem_we) begin
      for (int b = 0; b < 4; b++)
        if (a_mem_wstrb[b]) a_mem[a_mem_addr[9:2]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
    end
    a_rpipe <= a_mem_en ? a_mem[a_mem_addr[9:2]] : 32'hBAD0_BAD0;
  end
  assign a_mem_rdata = a_rpipe;

  // SRAM model B: three-cycle read pipeline, read-only contents.
  logic [31:0] b_mem [256];
  logic [31:0] b_p0, b_p1, b_p2;
  bit          b_init_done;
  always @(posedge clk) begin
    if (!b_init_done) begin
      for (int i = 0; i < 256; i++) b_mem[i] <= 32'h5B00_0000 | 32'(i);
      b_init_done <= 1'b1;
    end
    b_p0 <= b_mem_en ? b_mem[b_mem_addr[9:2]] : 32'hBAD0_BAD0;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_mem_rdata = b_p2;

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      P_A_IF_READY: probe = {31'b0, a_if_req_ready};
      P_A_D_READY:  probe = {31'b0, a_d_req_ready};
      P_A_MEM_EN:   probe = {31'b0, a_mem_en};
      P_A_MEM_ADDR: probe = a_mem_addr;
      P_A_MEM_WE:   probe = {31'b0, a_mem_we};
      P_A_OUT_OR:   probe = {21'b0, a_if_req_ready, a_if_rsp_valid, |a_if_rsp_rdata,
                             a_d_req_ready, a_d_rsp_valid, |a_d_rsp_rdata, a_mem_en,
                             a_mem_we, |a_mem_addr, |a_mem_wdata, |a_mem_wstrb};
      P_B_OUT_OR:   probe = {21'b0, b_if_req_ready, b_if_rsp_valid, |b_if_rsp_rdata,
                             b_d_req_ready, b_d_rsp_valid, |b_d_rsp_rdata, b_mem_en,
                             b_mem_we, |b_mem_addr, |b_mem_wdata, |b_mem_wstrb};
      P_A_IF_RDATA: probe = a_if_rsp_rdata;
      P_B_RSP_ANY:  probe = {31'b0, b_if_rsp_valid | b_d_rsp_valid};
      P_B_MEM_EN:   probe = {31'b0, b_mem_en};
      P_SB_LEFT:    probe = 32'(sb.size());
      P_TIMEOUTS:   probe = 32'(timeouts);
      default:      probe = 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic handleRsp(input int inst, input logic is_d, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL unexpected_rsp: inst %0d d_port %0b data %h, none required (cycle %0d)",
               inst, is_d, data, cyc);
    end else begin
      e = sb.pop_front();
      checkOutput("rsp_inst",  32'(inst), 32'(e.inst));
      checkOutput("rsp_port",  {31'b0, is_d}, {31'b0, e.is_d});
      checkOutput("rsp_data",  data, e.data);
      checkOutput("rsp_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Monitor: all comparisons happen here, half a cycle away from the edge.
  always @(negedge clk) begin
    if (a_if_rsp_valid) handleRsp(0, 1'b0, a_if_rsp_rdata);
    if (a_d_rsp_valid)  handleRsp(0, 1'b1, a_d_rsp_rdata);
    if (b_if_rsp_valid) handleRsp(1, 1'b0, b_if_rsp_rdata);
    if (b_d_rsp_valid)  handleRsp(1, 1'b1, b_d_rsp_rdata);
    if (a_if_req_valid && a_d_req_valid)
      checkOutput("ready_exclusive", {31'b0, a_if_req_ready & a_d_req_ready}, 32'd0);
    if (!a_mem_en)
      checkOutput("a_mem_idle_zero",
                  {31'b0, a_mem_we | (|a_mem_addr) | (|a_mem_wdata) | (|a_mem_wstrb)}, 32'd0);
    if (a_mem_en && !a_mem_we)
      checkOutput("a_read_fields_zero", {31'b0, (|a_mem_wdata) | (|a_mem_wstrb)}, 32'd0);
    if (!b_mem_en)
      checkOutput("b_mem_idle_zero",
                  {31'b0, b_mem_we | (|b_mem_addr) | (|b_mem_wdata) | (|b_mem_wstrb)}, 32'd0);
    for (int i = cq.size() - 1; i >= 0; i--) begin
      if (cq[i].cyc <= cyc) begin
        checkOutput(cq[i].name, probe(cq[i].sel), cq[i].exp);
        cq.delete(i);
      end
    end
  end

  task automatic pushExp(input int inst, input logic is_d, input logic [31:0] data, input int c);
    exp_t e;
    e.inst = inst; e.is_d = is_d; e.data = data; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic pushChk(input int c, input int sel, input logic [31:0] exp, input string name);
    chk_t k;
    k.cyc = c; k.sel = sel; k.exp = exp; k.name = name;
    cq.push_back(k);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reqIfA(input logic [31:0] addr);
    bit granted = 1'b0;
    a_if_req_valid = 1'b1;
    a_if_req_addr  = addr;
    for (int i = 0; i < TMO && !granted; i++) begin
      @(negedge clk);
      if (a_if_req_ready) granted = 1'b1;
    end
    if (!granted) timeouts++;
    @(posedge clk); #1;
    a_if_req_valid = 1'b0;
    a_if_req_addr  = '0;
  endtask

  task automatic reqDA(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    bit granted = 1'b0;
    a_d_req_valid = 1'b1;
    a_d_req_we    = we;
    a_d_req_addr  = addr;
    a_d_req_wdata = wdata;
    a_d_req_wstrb = wstrb;
    for (int i = 0; i < TMO && !granted; i++) begin
      @(negedge clk);
      if (a_d_req_ready) granted = 1'b1;
    end
    if (!granted) timeouts++;
    @(posedge clk); #1;
    a_d_req_valid = 1'b0;
    a_d_req_we    = 1'b0;
    a_d_req_addr  = '0;
    a_d_req_wdata = '0;
    a_d_req_wstrb = '0;
  endtask

  task automatic reqIfB(input logic [31:0] addr);
    bit granted = 1'b0;
    b_if_req_valid = 1'b1;
    b_if_req_addr  = addr;
    for (int i = 0; i < TMO && !granted; i++) begin
      @(negedge clk);
      if (b_if_req_ready) granted = 1'b1;
    end
    if (!granted) timeouts++;
    @(posedge clk); #1;
    b_if_req_valid = 1'b0;
    b_if_req_addr  = '0;
  endtask

  // Lone data request from IDLE: granted in its first cycle, response
  // MEM_LAT+2 cycles later.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic [31:0] exp_rdata);
    int s;
    s = cyc;
    pushExp(0, 1'b1, exp_rdata, s + 2 + LAT_A);
    pushChk(s, P_A_D_READY, 32'd1, "d_ready_lone");
    reqDA(we, addr, wdata, wstrb);
    idle(4);
  endtask

  int          s;
  int          gofs [7] = '{0, 3, 6, 9, 12, 15, 18};
  logic        gisd [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] gexp [7] = '{32'h5A00_0020, 32'h5A00_0021, 32'h5A00_0022, 32'h5A00_0023,
                            32'h5A00_0040, 32'h5A00_0024, 32'h5A00_0041};

  initial begin
    rst = 1'b1;
    a_if_req_valid = 1'b0; a_if_req_addr = '0;
    a_d_req_valid = 1'b0; a_d_req_we = 1'b0; a_d_req_addr = '0; a_d_req_wdata = '0; a_d_req_wstrb = '0;
    b_if_req_valid = 1'b0; b_if_req_addr = '0;
    b_d_req_valid = 1'b0; b_d_req_we = 1'b0; b_d_req_addr = '0; b_d_req_wdata = '0; b_d_req_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    pushChk(cyc, P_A_OUT_OR, 32'd0, "reset_outputs_a");
    pushChk(cyc, P_B_OUT_OR, 32'd0, "reset_outputs_b");
    idle(1);

    $display("[TB] fetch read, MEM_LAT=1");
    s = cyc;
    pushExp(0, 1'b0, 32'hDEAD_BEEF, s + 2 + LAT_A);
    pushChk(s,     P_A_IF_READY, 32'd1,     "t1_if_ready");
    pushChk(s + 1, P_A_MEM_EN,   32'd1,     "t1_mem_en");
    pushChk(s + 1, P_A_MEM_ADDR, 32'h10,    "t1_mem_addr");
    pushChk(s + 1, P_A_MEM_WE,   32'd0,     "t1_mem_we");
    pushChk(s + 2, P_A_MEM_EN,   32'd0,     "t1_mem_en_once");
    pushChk(s + 6, P_A_IF_RDATA, 32'hDEAD_BEEF, "t1_rdata_hold");
    reqIfA(32'h10);
    idle(6);

    $display("[TB] data writes with byte strobes");
    applyStimulus(1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'h0);
    applyStimulus(1'b0, 32'h20, 32'h0,         4'h0, 32'h1234_5678);
    applyStimulus(1'b1, 32'h20, 32'hAAAA_AAAA, 4'h2, 32'h0);
    applyStimulus(1'b0, 32'h20, 32'h0,         4'h0, 32'h1234_AA78);

    $display("[TB] simultaneous requests from IDLE");
    s = cyc;
    pushExp(0, 1'b1, 32'hDEAD_BEEF, s + 3);
    pushExp(0, 1'b0, 32'h5A00_0005, s + 6);
    pushChk(s,     P_A_D_READY,  32'd1, "t3_d_first");
    pushChk(s,     P_A_IF_READY, 32'd0, "t3_if_waits");
    pushChk(s + 3, P_A_IF_READY, 32'd1, "t3_if_in_resp");
    fork
      reqDA(1'b0, 32'h10, 32'h0, 4'h0);
      reqIfA(32'h14);
    join
    idle(6);

    $display("[TB] starvation limit");
    s = cyc;
    for (int k = 0; k < 7; k++) begin
      pushExp(0, gisd[k], gexp[k], s + gofs[k] + 3);
      pushChk(s + gofs[k], gisd[k] ? P_A_D_READY : P_A_IF_READY, 32'd1, "t4_winner_ready");
      if (k < 6)
        pushChk(s + gofs[k], gisd[k] ? P_A_IF_READY : P_A_D_READY, 32'd0, "t4_loser_ready");
    end
    fork
      begin
        for (int k = 0; k < 5; k++) reqDA(1'b0, 32'h80 + 32'(4 * k), 32'h0, 4'h0);
      end
      begin
        reqIfA(32'h100);
        reqIfA(32'h104);
      end
    join
    idle(6);

    $display("[TB] MEM_LAT=3 latency and mid-transaction reset");
    s = cyc;
    pushExp(1, 1'b0, 32'h5B00_0004, s + 2 + LAT_B);
    pushChk(s + 1, P_B_MEM_EN, 32'd1, "t5_mem_en");
    pushChk(s + 2, P_B_MEM_EN, 32'd0, "t5_mem_en_once");
    reqIfB(32'h10);
    idle(8);

    s = cyc;
    pushChk(s + 4, P_B_OUT_OR, 32'd0, "t5_post_reset_outputs_b");
    pushChk(s + 4, P_A_OUT_OR, 32'd0, "t5_post_reset_outputs_a");
    for (int j = 5; j <= 10; j++) pushChk(s + j, P_B_RSP_ANY, 32'd0, "t5_no_rsp_after_reset");
    reqIfB(32'h14);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(8);

    s = cyc;
    pushExp(1, 1'b0, 32'h5B00_0006, s + 2 + LAT_B);
    reqIfB(32'h18);
    idle(8);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    pushChk(cyc + 1, P_SB_LEFT,  32'd0, "sb_leftover");
    pushChk(cyc + 1, P_TIMEOUTS, 32'd0, "grant_timeouts");
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
